// File: rtl/eeprom_spi_shifter_pkg.sv
// -----------------------------------------------------------------------------
// eeprom_spi_shifter_pkg
// Shared definitions for the EEPROM SPI byte shifter: FSM state encoding and
// SPI mode-0 constants. Imported by the shifter RTL and by its testbench.
// -----------------------------------------------------------------------------
package eeprom_spi_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_DONE     = 2'd3
    } spi_state_e;

    // Mode 0: CPOL = 0 (SCK idles low), CPHA = 0 (sample on SCK rising edge).
    localparam logic SCK_IDLE   = 1'b0;
    localparam logic SCK_ACTIVE = 1'b1;

    localparam int BITS_PER_BYTE = 8;

    // Width of a down-counter that must hold values up to max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/eeprom_spi_shifter.sv
// -----------------------------------------------------------------------------
// eeprom_spi_shifter
// SPI mode-0 master byte shifter for the EEPROM page-write path. Transmits one
// byte MSB first on mosi while capturing the byte returned on miso.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   load_data : one-cycle strobe, start a byte (accepted in IDLE/DONE with nCS=0)
//   data_in   : byte to transmit, sampled on an accepted load_data
//   nCS       : chip select from page-write controller (1 = deselected, aborts)
//   miso      : serial data from the EEPROM
//   sck       : SPI clock, idle low
//   mosi      : serial data to the EEPROM
//   rx_data   : last fully received byte
//   spi_busy  : high while a byte is in flight
//   byte_done : one-cycle pulse when a byte completes
//   overrun   : one-cycle pulse when load_data arrives mid-byte and is dropped
//
// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no transfer, sck low, mosi holds last bit
// SHIFT_LO   | sck low for CLK_DIV cycles, mosi carries current bit
// SHIFT_HI   | sck high for CLK_DIV cycles, miso sampled on entry
// DONE       | one cycle: byte_done pulse, rx_data updated, may accept next
// -----------------------------------------------------------------------------
module eeprom_spi_shifter
    import eeprom_spi_shifter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_data,
    input  logic [7:0] data_in,
    input  logic       nCS,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       spi_busy,
    output logic       byte_done,
    output logic       overrun
);

    localparam int DIV_W = cnt_width(int'(CLK_DIV));
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    // Holds the bits still to be sent after the one currently on mosi.
    logic [6:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             byte_done_q, byte_done_d;
    logic             overrun_q, overrun_d;

    logic             accept;

    assign accept = load_data && !nCS;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        byte_done_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE falls through to IDLE unless a new byte is queued,
                // which gives back-to-back bytes with no idle cycle.
                state_d = ST_IDLE;
                sck_d   = SCK_IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    state_d    = ST_SHIFT_LO;
                    tx_shift_d = data_in[6:0];
                    mosi_d     = data_in[7];
                    bit_cnt_d  = BIT_LAST;
                    div_d      = DIV_LOAD;
                    busy_d     = 1'b1;
                end
            end

            ST_SHIFT_LO: begin
                overrun_d = load_data;
                if (nCS) begin
                    state_d = ST_IDLE;
                    sck_d   = SCK_IDLE;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else if (div_q == '0) begin
                    state_d    = ST_SHIFT_HI;
                    sck_d      = SCK_ACTIVE;
                    div_d      = DIV_LOAD;
                    rx_shift_d = {rx_shift_q[6:0], miso};
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            ST_SHIFT_HI: begin
                overrun_d = load_data;
                if (nCS) begin
                    state_d = ST_IDLE;
                    sck_d   = SCK_IDLE;
                    busy_d  = 1'b0;
                    div_d   = '0;
                end else if (div_q == '0) begin
                    sck_d = SCK_IDLE;
                    if (bit_cnt_q != 3'd0) begin
                        state_d    = ST_SHIFT_LO;
                        bit_cnt_d  = bit_cnt_q - 3'd1;
                        mosi_d     = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        div_d      = DIV_LOAD;
                    end else begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        byte_done_d = 1'b1;
                        rx_data_d   = rx_shift_q;
                        div_d       = '0;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sck_d   = SCK_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            sck_q       <= SCK_IDLE;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign rx_data   = rx_data_q;
    assign spi_busy  = busy_q;
    assign byte_done = byte_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_eeprom_spi_shifter.sv
// -----------------------------------------------------------------------------
// tb_eeprom_spi_shifter
// Directed bench for eeprom_spi_shifter. Two instances: CLK_DIV=2 for single
// byte, overrun, abort, nCS and reset scenarios; CLK_DIV=1 for back-to-back.
// -----------------------------------------------------------------------------
module tb_eeprom_spi_shifter;
    import eeprom_spi_shifter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // CLK_DIV = 2 instance
    logic       load2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       ncs2 = 1'b0;
    logic       miso2;
    logic       sck2, mosi2, busy2, done2, ovr2;
    logic [7:0] rx2;
    bit         lb2 = 1'b1;
    logic       miso_bit2 = 1'b0;
    assign miso2 = lb2 ? mosi2 : miso_bit2;

    // CLK_DIV = 1 instance, loopback
    logic       load1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ncs1 = 1'b0;
    logic       miso1;
    logic       sck1, mosi1, busy1, done1, ovr1;
    logic [7:0] rx1;
    assign miso1 = mosi1;

    eeprom_spi_shifter #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .load_data(load2), .data_in(data2),
        .nCS(ncs2), .miso(miso2), .sck(sck2), .mosi(mosi2), .rx_data(rx2),
        .spi_busy(busy2), .byte_done(done2), .overrun(ovr2)
    );

    eeprom_spi_shifter #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .load_data(load1), .data_in(data1),
        .nCS(ncs1), .miso(miso1), .sck(sck1), .mosi(mosi1), .rx_data(rx1),
        .spi_busy(busy1), .byte_done(done1), .overrun(ovr1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] mpat;
        bit         lb;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    // Runs one byte on the CLK_DIV=2 instance, starting just after a negedge.
    // ovr_at: cycle index (after accept) to pulse load_data, 0 = never.
    // abort_rise: raise nCS after this SCK rise, 0 = never.
    task automatic run2(input logic [7:0] d, input logic [7:0] mpat, input bit lb,
                        input int ovr_at, input int abort_rise,
                        output logic [7:0] mosi_seen, output int done_cyc,
                        output int nrise, output int novr, output int ndone,
                        output int sck_ab, output int busy_ab, output int busy_c1);
        int  abort_cyc;
        bit  prev_sck;
        mosi_seen = 8'h00; done_cyc = -1; nrise = 0; novr = 0; ndone = 0;
        sck_ab = -1; busy_ab = -1; busy_c1 = -1; abort_cyc = -1; prev_sck = 1'b0;
        lb2 = lb;
        miso_bit2 = mpat[7];
        data2 = d;
        load2 = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            load2 = (ovr_at != 0 && cyc == ovr_at);
            if (load2) data2 = 8'hFF;
            if (cyc == 1) busy_c1 = int'(busy2);
            if (ovr2) novr++;
            if (sck2 && !prev_sck) begin
                if (nrise < 8) mosi_seen[7 - nrise] = mosi2;
                nrise++;
                if (abort_rise != 0 && nrise == abort_rise) begin
                    ncs2 = 1'b1;
                    abort_cyc = cyc;
                end
            end
            prev_sck = sck2;
            if (!sck2 && nrise < 8) miso_bit2 = mpat[7 - nrise];
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                sck_ab = int'(sck2);
                busy_ab = int'(busy2);
            end
            if (done2) begin
                done_cyc = cyc;
                ndone++;
                if (abort_cyc < 0) break;
            end
            if (abort_cyc > 0 && cyc == abort_cyc + 40) break;
        end
        load2 = 1'b0;
    endtask

    logic [7:0] ms;
    int dc, nr, nov, nd, sab, bab, bc1;
    logic [7:0] rx_before;

    initial begin
        vecs[0] = '{data: 8'hA5, mpat: 8'h00, lb: 1'b1, exp_rx: 8'hA5};
        vecs[1] = '{data: 8'h3C, mpat: 8'hC3, lb: 1'b0, exp_rx: 8'hC3};
        vecs[2] = '{data: 8'hFF, mpat: 8'h00, lb: 1'b0, exp_rx: 8'h00};
        vecs[3] = '{data: 8'h00, mpat: 8'h81, lb: 1'b0, exp_rx: 8'h81};
        vecs[4] = '{data: 8'h81, mpat: 8'h00, lb: 1'b1, exp_rx: 8'h81};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sck", int'(sck2), int'(SCK_IDLE));
        chk("rst_mosi", int'(mosi2), 0);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_ovr", int'(ovr2), 0);
        chk("rst_rx", int'(rx2), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single bytes on CLK_DIV=2
        foreach (vecs[i]) begin
            run2(vecs[i].data, vecs[i].mpat, vecs[i].lb, 0, 0, ms, dc, nr, nov, nd, sab, bab, bc1);
            chk($sformatf("v%0d_mosi", i), int'(ms), int'(vecs[i].data));
            chk($sformatf("v%0d_done_cyc", i), dc, 33);
            chk($sformatf("v%0d_rises", i), nr, 8);
            chk($sformatf("v%0d_rx", i), int'(rx2), int'(vecs[i].exp_rx));
            chk($sformatf("v%0d_busy_c1", i), bc1, 1);
            chk($sformatf("v%0d_busy_done", i), int'(busy2), 0);
            chk($sformatf("v%0d_ovr", i), nov, 0);
            repeat (2) @(negedge clk);
        end

        // Overrun: load_data again 5 cycles into the byte
        run2(8'h5A, 8'h96, 1'b0, 5, 0, ms, dc, nr, nov, nd, sab, bab, bc1);
        chk("ovr_count", nov, 1);
        chk("ovr_mosi", int'(ms), 8'h5A);
        chk("ovr_done_cyc", dc, 33);
        chk("ovr_rx", int'(rx2), 8'h96);
        repeat (2) @(negedge clk);

        // Abort by nCS after the third SCK rise
        rx_before = rx2;
        run2(8'hE7, 8'h00, 1'b1, 0, 3, ms, dc, nr, nov, nd, sab, bab, bc1);
        chk("abort_sck", sab, 0);
        chk("abort_busy", bab, 0);
        chk("abort_ndone", nd, 0);
        chk("abort_rises", nr, 3);
        chk("abort_rx", int'(rx2), 8'h96);
        ncs2 = 1'b0;
        repeat (2) @(negedge clk);

        // load_data while deselected
        begin
            int rises = 0, busy_hi = 0, ovrs = 0;
            bit p = 1'b0;
            ncs2 = 1'b1;
            data2 = 8'hAA;
            load2 = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                load2 = 1'b0;
                if (sck2 && !p) rises++;
                p = sck2;
                if (busy2) busy_hi++;
                if (ovr2) ovrs++;
            end
            chk("ncs_rises", rises, 0);
            chk("ncs_busy", busy_hi, 0);
            chk("ncs_ovr", ovrs, 0);
            chk("ncs_rx", int'(rx2), 8'h96);
            ncs2 = 1'b0;
        end

        // Reset mid-byte, then a fresh byte
        begin
            int dones = 0;
            lb2 = 1'b1;
            data2 = 8'h77;
            load2 = 1'b1;
            @(negedge clk);
            load2 = 1'b0;
            repeat (9) @(negedge clk);
            chk("rmid_busy_pre", int'(busy2), 1);
            reset = 1'b0;
            #1;
            chk("rmid_sck", int'(sck2), 0);
            chk("rmid_mosi", int'(mosi2), 0);
            chk("rmid_busy", int'(busy2), 0);
            chk("rmid_rx", int'(rx2), 0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (done2) dones++;
            end
            chk("rmid_no_done", dones, 0);
            run2(8'h3C, 8'h00, 1'b1, 0, 0, ms, dc, nr, nov, nd, sab, bab, bc1);
            chk("rmid_mosi_seq", int'(ms), 8'h3C);
            chk("rmid_done_cyc", dc, 33);
            chk("rmid_rx_after", int'(rx2), 8'h3C);
        end

        // Back-to-back bytes on CLK_DIV=1, reloaded in each DONE cycle
        begin
            logic [7:0]  bytes [3];
            int          done_at [3];
            logic [7:0]  rx_at [3];
            logic [23:0] mosi_all;
            int idx = 1, ndn = 0, rises = 0, last_rise = -1, max_gap = 0;
            bit p = 1'b0;
            bytes[0] = 8'h02; bytes[1] = 8'h00; bytes[2] = 8'h10;
            mosi_all = '0;
            foreach (done_at[i]) begin done_at[i] = -1; rx_at[i] = 8'hEE; end
            @(negedge clk);
            data1 = bytes[0];
            load1 = 1'b1;
            for (int cyc = 1; cyc <= 70; cyc++) begin
                @(negedge clk);
                load1 = 1'b0;
                if (sck1 && !p) begin
                    if (rises < 24) mosi_all[23 - rises] = mosi1;
                    if (last_rise >= 0 && cyc - last_rise > max_gap) max_gap = cyc - last_rise;
                    last_rise = cyc;
                    rises++;
                end
                p = sck1;
                if (done1) begin
                    if (ndn < 3) begin
                        done_at[ndn] = cyc;
                        rx_at[ndn] = rx1;
                    end
                    ndn++;
                    if (idx < 3) begin
                        data1 = bytes[idx];
                        load1 = 1'b1;
                        idx++;
                    end
                end
            end
            chk("b2b_rises", rises, 24);
            chk("b2b_max_gap", max_gap, 3);
            chk("b2b_mosi", int'(mosi_all), 24'h020010);
            chk("b2b_ndone", ndn, 3);
            chk("b2b_done0", done_at[0], 17);
            chk("b2b_done1", done_at[1], 34);
            chk("b2b_done2", done_at[2], 51);
            chk("b2b_rx0", int'(rx_at[0]), 8'h02);
            chk("b2b_rx1", int'(rx_at[1]), 8'h00);
            chk("b2b_rx2", int'(rx_at[2]), 8'h10);
            chk("b2b_ovr", int'(ovr1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
